// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 plaintext feeder: block/byte geometry
// and the feeder's state encoding.
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLOK_W      = 128;
   localparam int AES_BAYT_W      = 8;
   localparam int AES_BAYT_SAYISI = 16;

   // TOPLA: collecting bytes, DOLGU: writing PKCS#7 pad bytes,
   // GONDER: block offered to the engine.
   typedef enum logic [1:0] {
      TOPLA  = 2'd0,
      DOLGU  = 2'd1,
      GONDER = 2'd2
   } durum_e;

endpackage : aes_pkg

// File: rtl/aes_blok_toplayici.sv
// ---------------------------------------------------------------------------
// aes_blok_toplayici
// Packs a byte-serial plaintext stream into 128-bit blocks for the AES-128
// engine and holds each block stable until the engine accepts it.
//
// Build option: define AES_PKCS7_EN to pad the final block of each message
// with PKCS#7 bytes (a whole-block message gets an extra 16 x 0x10 block).
// Without it, a short final block is zero-filled and sent as is.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   v_veri      plaintext byte
//   v_gecerli   v_veri valid
//   v_son       current byte is the last of the message (with v_gecerli)
//   v_hazir     feeder can take a byte this cycle
//   blok        assembled block, byte 0 at [127:120]
//   g_gecerli   blok valid and offered to the engine
//   hazir       engine ready
//   blok_sayac  number of blocks handed to the engine (wraps)
// ---------------------------------------------------------------------------
module aes_blok_toplayici
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AES_BAYT_W-1:0] v_veri,
   input  logic                  v_gecerli,
   input  logic                  v_son,
   output logic                  v_hazir,
   output logic [AES_BLOK_W-1:0] blok,
   output logic                  g_gecerli,
   input  logic                  hazir,
   output logic [31:0]           blok_sayac
);

   durum_e                state_q, state_d;
   logic [3:0]            say_q, say_d;
   logic [AES_BLOK_W-1:0] blok_q, blok_d;
   logic [31:0]           blok_sayac_q, blok_sayac_d;
   logic                  bayt_al;

`ifdef AES_PKCS7_EN
   logic ek_dolgu_q, ek_dolgu_d;

   // Lanes n..15 get the pad value 16-n; n==0 therefore fills all lanes
   // with 0x10, which is the extra block for whole-block messages.
   function automatic logic [AES_BLOK_W-1:0] pad_fill(
      input logic [AES_BLOK_W-1:0] b,
      input logic [3:0]            n
   );
      logic [AES_BLOK_W-1:0] r;
      logic [AES_BAYT_W-1:0] deger;
      r     = b;
      deger = 8'(AES_BAYT_SAYISI) - {4'd0, n};
      for (int i = 0; i < AES_BAYT_SAYISI; i++) begin
         if (i >= int'(n)) r[(AES_BAYT_SAYISI-1-i)*AES_BAYT_W +: AES_BAYT_W] = deger;
      end
      return r;
   endfunction
`endif

   assign v_hazir    = (state_q == TOPLA) && !rst;
   // Decoded straight from the state flop, so hazir never reaches it
   // combinationally.
   assign g_gecerli  = (state_q == GONDER);
   assign blok       = blok_q;
   assign blok_sayac = blok_sayac_q;
   assign bayt_al    = v_gecerli && v_hazir;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it
      // unassigned, which would infer a latch.
      state_d      = state_q;
      say_d        = say_q;
      blok_d       = blok_q;
      blok_sayac_d = blok_sayac_q;
`ifdef AES_PKCS7_EN
      ek_dolgu_d   = ek_dolgu_q;
`endif
      case (state_q)
         TOPLA: begin
            if (bayt_al) begin
               blok_d[(AES_BAYT_SAYISI-1-int'(say_q))*AES_BAYT_W +: AES_BAYT_W] = v_veri;
               say_d = say_q + 4'd1;       // wraps to 0 after lane 15
               if (say_q == 4'd15) begin
                  state_d = GONDER;
`ifdef AES_PKCS7_EN
                  ek_dolgu_d = v_son;       // whole-block message: pad block follows
`endif
               end else if (v_son) begin
`ifdef AES_PKCS7_EN
                  state_d = DOLGU;          // say_d now holds the byte count n
`else
                  state_d = GONDER;         // remaining lanes are already zero
                  say_d   = 4'd0;
`endif
               end
            end
         end
`ifdef AES_PKCS7_EN
         DOLGU: begin
            blok_d     = pad_fill(blok_q, say_q);
            ek_dolgu_d = 1'b0;
            say_d      = 4'd0;
            state_d    = GONDER;
         end
`endif
         GONDER: begin
            if (hazir) begin
               blok_sayac_d = blok_sayac_q + 32'd1;
               // Clearing here is what makes unwritten lanes read 0x00 later.
               blok_d       = '0;
               say_d        = 4'd0;
`ifdef AES_PKCS7_EN
               state_d      = ek_dolgu_q ? DOLGU : TOPLA;
`else
               state_d      = TOPLA;
`endif
            end
         end
         default: state_d = TOPLA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= TOPLA;
         say_q        <= 4'd0;
         blok_q       <= '0;
         blok_sayac_q <= 32'd0;
`ifdef AES_PKCS7_EN
         ek_dolgu_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so all flops update together from the old values.
         state_q      <= state_d;
         say_q        <= say_d;
         blok_q       <= blok_d;
         blok_sayac_q <= blok_sayac_d;
`ifdef AES_PKCS7_EN
         ek_dolgu_q   <= ek_dolgu_d;
`endif
      end
   end

endmodule : aes_blok_toplayici

// File: tb/tb_aes_blok_toplayici.sv
// ---------------------------------------------------------------------------
// tb_aes_blok_toplayici
// Directed self-checking bench for aes_blok_toplayici. Expectations follow
// the build: AES_PKCS7_EN selects the padded results.
// ---------------------------------------------------------------------------
module tb_aes_blok_toplayici;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   v_veri;
   logic         v_gecerli;
   logic         v_son;
   logic         v_hazir;
   logic [127:0] blok;
   logic         g_gecerli;
   logic         hazir;
   logic [31:0]  blok_sayac;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [127:0] BLK_00_0F = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] BLK_10_1F = 128'h101112131415161718191A1B1C1D1E1F;
   localparam logic [127:0] BLK_ABC_P = 128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D;
   localparam logic [127:0] BLK_ABC_Z = 128'hAABBCC00000000000000000000000000;
   localparam logic [127:0] BLK_ALL10 = {16{8'h10}};

   aes_blok_toplayici dut (
      .clk        (clk),
      .rst        (rst),
      .v_veri     (v_veri),
      .v_gecerli  (v_gecerli),
      .v_son      (v_son),
      .v_hazir    (v_hazir),
      .blok       (blok),
      .g_gecerli  (g_gecerli),
      .hazir      (hazir),
      .blok_sayac (blok_sayac)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One byte per cycle starting at 'first'; v_son on the last if 'son'.
   task automatic send_bytes(input logic [7:0] first, input int count, input logic son);
      for (int i = 0; i < count; i++) begin
         v_veri    = first + 8'(i);
         v_gecerli = 1'b1;
         v_son     = son && (i == count - 1);
         tick();
      end
      v_gecerli = 1'b0;
      v_son     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; v_veri = 8'h00; v_gecerli = 1'b0; v_son = 1'b0; hazir = 1'b0;
      tick();
      chk("v_hazir_in_reset", {127'd0, v_hazir}, 128'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("reset_g_gecerli", {127'd0, g_gecerli}, 128'd0);
      chk("reset_blok", blok, 128'd0);
      chk("reset_sayac", {96'd0, blok_sayac}, 128'd0);
      chk("reset_v_hazir", {127'd0, v_hazir}, 128'd1);

      // 1: full block, engine ready
      hazir = 1'b1;
      send_bytes(8'h00, 16, 1'b0);
      chk("t1_g_gecerli", {127'd0, g_gecerli}, 128'd1);
      chk("t1_blok", blok, BLK_00_0F);
      tick();
      chk("t1_after_g", {127'd0, g_gecerli}, 128'd0);
      chk("t1_after_vh", {127'd0, v_hazir}, 128'd1);
      chk("t1_sayac", {96'd0, blok_sayac}, 128'd1);
      chk("t1_cleared", blok, 128'd0);

      // 2: engine stalls 5 cycles
      hazir = 1'b0;
      send_bytes(8'h00, 16, 1'b0);
      for (int c = 0; c < 5; c++) begin
         chk("t2_hold_g", {127'd0, g_gecerli}, 128'd1);
         chk("t2_hold_blok", blok, BLK_00_0F);
         chk("t2_hold_vh", {127'd0, v_hazir}, 128'd0);
         chk("t2_hold_sayac", {96'd0, blok_sayac}, 128'd1);
         tick();
      end
      hazir = 1'b1;
      tick();
      chk("t2_after_g", {127'd0, g_gecerli}, 128'd0);
      chk("t2_sayac", {96'd0, blok_sayac}, 128'd2);

      // 3: short message AA BB CC
      hazir = 1'b0;
      v_veri = 8'hAA; v_gecerli = 1'b1; tick();
      v_veri = 8'hBB; tick();
      v_veri = 8'hCC; v_son = 1'b1; tick();
      v_gecerli = 1'b0; v_son = 1'b0;
`ifdef AES_PKCS7_EN
      chk("t3_dolgu_g", {127'd0, g_gecerli}, 128'd0);
      chk("t3_dolgu_vh", {127'd0, v_hazir}, 128'd0);
      tick();
      chk("t3_g_gecerli", {127'd0, g_gecerli}, 128'd1);
      chk("t3_blok", blok, BLK_ABC_P);
`else
      chk("t3_g_gecerli", {127'd0, g_gecerli}, 128'd1);
      chk("t3_blok", blok, BLK_ABC_Z);
`endif
      hazir = 1'b1;
      tick();
      chk("t3_after_g", {127'd0, g_gecerli}, 128'd0);
      chk("t3_sayac", {96'd0, blok_sayac}, 128'd3);
      tick();
      chk("t3_no_extra", {127'd0, g_gecerli}, 128'd0);

      // 4: 16-byte message ending on a block boundary
      send_bytes(8'h00, 16, 1'b1);
      chk("t4_g_gecerli", {127'd0, g_gecerli}, 128'd1);
      chk("t4_blok", blok, BLK_00_0F);
      tick();
      chk("t4_after_g", {127'd0, g_gecerli}, 128'd0);
      chk("t4_sayac1", {96'd0, blok_sayac}, 128'd4);
`ifdef AES_PKCS7_EN
      chk("t4_dolgu_vh", {127'd0, v_hazir}, 128'd0);
      tick();
      chk("t4_pad_g", {127'd0, g_gecerli}, 128'd1);
      chk("t4_pad_blok", blok, BLK_ALL10);
      tick();
      chk("t4_pad_after_g", {127'd0, g_gecerli}, 128'd0);
      chk("t4_sayac2", {96'd0, blok_sayac}, 128'd5);
      chk("t4_vh", {127'd0, v_hazir}, 128'd1);
`else
      chk("t4_vh", {127'd0, v_hazir}, 128'd1);
      tick();
      chk("t4_no_extra", {127'd0, g_gecerli}, 128'd0);
      chk("t4_sayac2", {96'd0, blok_sayac}, 128'd4);
`endif

      // 5: reset after 7 bytes, then a fresh block
      send_bytes(8'h40, 7, 1'b0);
      rst = 1'b1;
      tick();
      chk("t5_vh_in_reset", {127'd0, v_hazir}, 128'd0);
      rst = 1'b0;
      #1;
      chk("t5_sayac_reset", {96'd0, blok_sayac}, 128'd0);
      send_bytes(8'h10, 16, 1'b0);
      chk("t5_g_gecerli", {127'd0, g_gecerli}, 128'd1);
      chk("t5_blok", blok, BLK_10_1F);
      tick();
      chk("t5_sayac", {96'd0, blok_sayac}, 128'd1);

      // 6: reset while a block is being offered
      hazir = 1'b0;
      send_bytes(8'h10, 16, 1'b0);
      chk("t6_g_before", {127'd0, g_gecerli}, 128'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_g_after_rst", {127'd0, g_gecerli}, 128'd0);
      chk("t6_blok_after_rst", blok, 128'd0);
      chk("t6_sayac_after_rst", {96'd0, blok_sayac}, 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_aes_blok_toplayici
